apb_master: RTL and testbench



---
 rtl/apb_master.sv | 195 +++++++++++++++++++
 tb/tb_apb_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB4 requester: turns single-beat local commands into APB SETUP/ACCESS transfers.
// Target slave is decoded from cmd_addr[SEL_LSB +: SEL_BITS]; out-of-range indices
// answer immediately with an error and never touch the bus.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned PROT_WIDTH     = 3,
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned SEL_LSB        = 12,
    parameter int unsigned SEL_BITS       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    // Local command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [STROBE_WIDTH-1:0] cmd_strb,
    input  logic [PROT_WIDTH-1:0]   cmd_prot,
    // Local response port
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    // APB bus
    output logic [NUM_SLAVES-1:0]   PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [STROBE_WIDTH-1:0] PSTRB,
    output logic [PROT_WIDTH-1:0]   PPROT,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic [DATA_WIDTH-1:0]   PRDATA
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STROBE_WIDTH-1:0] pstrb_q, pstrb_d;
    logic [PROT_WIDTH-1:0]   pprot_q, pprot_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [SEL_BITS-1:0]     sel_idx;
    logic                    sel_ok;
    logic [NUM_SLAVES-1:0]   psel_dec;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_q, tmo_d;
`else
    // TIMEOUT_CYCLES only matters when the timeout counter is built.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign sel_idx   = cmd_addr[SEL_LSB +: SEL_BITS];
    assign sel_ok    = 32'(sel_idx) < NUM_SLAVES;
    assign cmd_ready = (state_q == StIdle) && !PRESET;

    // One-hot slave select decoded from the address index field.
    always_comb begin
        psel_dec = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            psel_dec[i] = (32'(sel_idx) == i);
        end
    end

    // Next-state and next-output logic for the SETUP/ACCESS sequencer.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    if (sel_ok) begin
                        paddr_d   = cmd_addr;
                        pwrite_d  = cmd_write;
                        // Reads never expose stale write data or strobes on the bus.
                        pwdata_d  = cmd_write ? cmd_wdata : '0;
                        pstrb_d   = cmd_write ? cmd_strb : '0;
                        pprot_d   = cmd_prot;
                        psel_d    = psel_dec;
                        penable_d = 1'b0;
                        state_d   = StSetup;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
`ifdef APB_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            StAccess: begin
                if (PREADY) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
                end
`ifdef APB_TIMEOUT_EN
                // This is the last permitted wait cycle: abort the transfer.
                else if (tmo_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; synchronous reset clears everything.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed steps, response scoreboard,
// plus a second instance with NUM_SLAVES = 1 for the decode-error path.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_valid1 = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;
    logic [31:0] PRDATA = '0;

    logic        cmd_ready, rsp_valid, rsp_err, PENABLE, PWRITE;
    logic [31:0] rsp_rdata, PADDR, PWDATA;
    logic [1:0]  PSEL;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;

    logic        cmd_ready1, rsp_valid1, rsp_err1, penable1, pwrite1;
    logic [31:0] rsp_rdata1, paddr1, pwdata1;
    logic [0:0]  psel1;
    logic [3:0]  pstrb1;
    logic [2:0]  pprot1;

    apb_master u_dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    apb_master #(.NUM_SLAVES(1)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .PSEL(psel1), .PENABLE(penable1), .PWRITE(pwrite1), .PADDR(paddr1), .PWDATA(pwdata1),
        .PSTRB(pstrb1), .PPROT(pprot1), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int unsigned cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Slave model: PREADY after wait_states ACCESS cycles, never while stalled.
    int unsigned wait_states = 0;
    logic        stall = 1'b0;
    int unsigned acc_cnt = 0;
    always @(negedge PCLK) begin
        if (|PSEL && PENABLE) acc_cnt = acc_cnt + 1;
        else acc_cnt = 0;
        PREADY = !stall && (acc_cnt > wait_states);
    end

    // Response monitor: every rsp_valid must match the oldest expectation, on time.
    always @(negedge PCLK) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("spurious_rsp", rsp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_err", rsp_err, e.err);
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_cycle", cyc, e.due);
            end
        end
    end

    // Waits for cmd_ready, presents one command, returns at the SETUP-cycle negedge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input logic push,
                         input logic err, input logic [31:0] rdata, input int unsigned lat);
        exp_t e;
        for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge PCLK);
        check("cmd_ready_before_issue", cmd_ready, 1'b1);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        cmd_prot  = prot;
        cmd_valid = 1'b1;
        if (push) begin
            e.err = err; e.rdata = rdata; e.due = cyc + lat;
            sb.push_back(e);
        end
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(negedge PCLK);
    endtask

    task automatic wait_rsp(input int unsigned bound);
        for (int unsigned i = 0; i < bound; i++) begin
            @(negedge PCLK);
            if (rsp_valid) break;
        end
        check("rsp_seen", rsp_valid, 1'b1);
    endtask

    initial begin
        logic        wr;
        logic [31:0] addr, rd;
        int unsigned ws;

        // Reset held for 3 cycles
        repeat (3) @(negedge PCLK);
        check("rst_psel", PSEL, 2'b00);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_pstrb", PSTRB, 4'h0);
        check("rst_pprot", PPROT, 3'h0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 34'h0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        PRESET = 1'b0;
        #1 check("cmd_ready_after_rst", cmd_ready, 1'b1);

        // Zero-wait write to slave 0
        wait_states = 0;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'h2, 1'b1, 1'b0, 32'h0, 3);
        check("wr_setup_psel", PSEL, 2'b01);
        check("wr_setup_penable", PENABLE, 1'b0);
        check("wr_setup_ctrl", {PWRITE, PADDR, PWDATA, PSTRB, PPROT},
              {1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'h2});
        check("wr_setup_ready", cmd_ready, 1'b0);
        @(negedge PCLK);
        check("wr_access_psel", PSEL, 2'b01);
        check("wr_access_penable", PENABLE, 1'b1);
        check("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);
        wait_rsp(20);
        check("wr_done_bus", {PSEL, PENABLE}, 3'b000);
        check("wr_done_paddr_held", PADDR, 32'h0000_0010);
        check("wr_done_ready", cmd_ready, 1'b1);

        // Read from slave 1 with 3 wait states, issued in the response cycle
        wait_states = 3;
        PRDATA = 32'h1234_5678;
        issue(1'b0, 32'h0000_1004, 32'hFFFF_FFFF, 4'hF, 3'h0, 1'b1, 1'b0, 32'h1234_5678, 6);
        check("rd_setup_psel", PSEL, 2'b10);
        check("rd_setup_pstrb", PSTRB, 4'h0);
        check("rd_setup_pwdata", PWDATA, 32'h0);
        check("rd_setup_pwrite", PWRITE, 1'b0);
        check("rd_setup_paddr", PADDR, 32'h0000_1004);
        repeat (2) @(negedge PCLK);
        check("rd_wait_hold", {PSEL, PENABLE, PADDR}, {2'b10, 1'b1, 32'h0000_1004});
        wait_rsp(20);

        // Read answered with PSLVERR
        wait_states = 0;
        PSLVERR = 1'b1;
        issue(1'b0, 32'h0000_0008, 32'h0, 4'h0, 3'h1, 1'b1, 1'b1, 32'h0, 3);
        wait_rsp(20);
        PSLVERR = 1'b0;

        // Mixed traffic, each command accepted in the previous response cycle
        for (int n = 0; n < 8; n++) begin
            wr = 1'($urandom_range(0, 1));
            addr = $urandom & 32'hFFFF_FFFC;
            rd = $urandom;
            ws = $urandom_range(0, 2);
            wait_states = ws;
            PRDATA = rd;
            issue(wr, addr, $urandom, 4'($urandom), 3'($urandom), 1'b1, 1'b0,
                  wr ? 32'h0 : rd, 3 + ws);
            check("mix_setup_psel", PSEL, addr[12] ? 2'b10 : 2'b01);
            wait_rsp(20);
        end

        // Single-slave instance: index 1 is a decode error, no bus activity
        cmd_addr = 32'h0000_1000;
        cmd_write = 1'b0;
        cmd_valid1 = 1'b1;
        #1 check("dec_ready", cmd_ready1, 1'b1);
        @(posedge PCLK);
        #1 cmd_valid1 = 1'b0;
        @(negedge PCLK);
        check("dec_rsp", {rsp_valid1, rsp_err1, rsp_rdata1}, {1'b1, 1'b1, 32'h0});
        check("dec_psel", psel1, 1'b0);
        check("dec_ready_again", cmd_ready1, 1'b1);
        check("dec_no_bus", {penable1, pwrite1, paddr1, pwdata1, pstrb1, pprot1}, 73'h0);
        @(negedge PCLK);
        check("dec_rsp_one_cycle", rsp_valid1, 1'b0);
        check("dec_psel_later", psel1, 1'b0);

        // Reset during the 2nd ACCESS cycle: transfer dropped, no response
        stall = 1'b1;
        issue(1'b0, 32'h0000_1008, 32'h0, 4'h0, 3'h5, 1'b0, 1'b0, 32'h0, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        check("mid_access_penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        @(negedge PCLK);
        check("mid_rst_bus", {PSEL, PENABLE, PADDR, PPROT}, 38'h0);
        check("mid_rst_rsp", rsp_valid, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b0);
        PRESET = 1'b0;
        #1 check("mid_rst_ready_release", cmd_ready, 1'b1);
        @(negedge PCLK);
        check("mid_rst_no_rsp", rsp_valid, 1'b0);

`ifdef APB_TIMEOUT_EN
        // Stuck slave: abort after 16 ACCESS cycles with an error
        issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 3'h0, 1'b1, 1'b1, 32'h0, 18);
        wait_rsp(40);
        check("tmo_bus_released", {PSEL, PENABLE}, 3'b000);
`else
        // Stuck slave without timeout: ACCESS is held indefinitely
        issue(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 3'h0, 1'b0, 1'b0, 32'h0, 0);
        repeat (30) @(negedge PCLK);
        check("stuck_still_access", {PSEL, PENABLE}, 3'b011);
        check("stuck_no_ready", cmd_ready, 1'b0);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
`endif
        stall = 1'b0;

        repeat (3) @(negedge PCLK);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
